// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port RAM between two requesters (port 0 = CPU,
//            port 1 = debug/IO loader). Serves one transaction at a time:
//            IDLE (arbitrate) -> ACC (drive RAM) -> RDW (read wait) -> IDLE.
//            Round-robin fairness by default. Defining MEM_ARB_FIXED_PRIO_EN
//            selects strict priority for port 0 instead.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic [1:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              grant,
  output logic              illegal_cmd
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RDW  = 2'd2
  } state_t;

  state_t            state;
  logic              op_write;
  logic              ram_write_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              m0_valid;
  logic              m1_valid;
  logic              win;
  logic [1:0]        win_cmd;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              rd_done;
  logic              done;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic              last_grant;
`endif

  assign m0_valid = (m0_cmd == CMD_READ) || (m0_cmd == CMD_WRITE);
  assign m1_valid = (m1_cmd == CMD_READ) || (m1_cmd == CMD_WRITE);

  // Pick the winner among valid requesters and select its request fields
  always_comb begin
    win = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = !m0_valid;
`else
    if (m0_valid && m1_valid) begin
      win = !last_grant;
    end else begin
      win = !m0_valid;
    end
`endif
    win_cmd   = win ? m1_cmd   : m0_cmd;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
  end

  // Transaction sequencer: arbitration, RAM drive, read wait, capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_write    <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cnt         <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      grant       <= 1'b0;
      illegal_cmd <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if ((m0_cmd == CMD_ILL) || (m1_cmd == CMD_ILL)) begin
            illegal_cmd <= 1'b1;
          end
          if (m0_valid || m1_valid) begin
            ram_addr    <= win_addr;
            ram_wdata   <= win_wdata;
            op_write    <= (win_cmd == CMD_WRITE);
            ram_write_q <= (win_cmd == CMD_WRITE);
            grant       <= win;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant  <= win;
`endif
            state       <= S_ACC;
          end
        end
        S_ACC: begin
          ram_write_q <= 1'b0;
          if (op_write) begin
            state <= S_IDLE;
          end else begin
            cnt   <= CNT_W'(RD_LAT);
            state <= S_RDW;
          end
        end
        S_RDW: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            if (grant) begin
              rdata1_q <= ram_rdata;
            end else begin
              rdata0_q <= ram_rdata;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          ram_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Completion decode; a reset sampled in the completing cycle suppresses
  // both the ready pulse and the RAM write so the aborted op leaves no trace
  always_comb begin
    rd_done   = (state == S_RDW) && (cnt == CNT_W'(1));
    done      = ((state == S_ACC) && op_write) || rd_done;
    m0_ready  = done && !grant && !reset;
    m1_ready  = done &&  grant && !reset;
    ram_write = ram_write_q && !reset;
    m0_rdata  = (rd_done && !grant) ? ram_rdata : rdata0_q;
    m1_rdata  = (rd_done &&  grant) ? ram_rdata : rdata1_q;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction RAM between two requesters.
  - Port 0: the CPU fetch/load-store path.
  - Port 1: a second master, such as a debug/IO loader that preloads or inspects memory.
- Sits between cpu/lab top-level glue and the RAM.
- Sequences each access: arbitration, RAM drive, read-latency wait, completion handshake.
- Serves one transaction at a time; round-robin fairness by default.

Parameters:
- ADDR_W, 9, RAM word-address width.
- DATA_W, 16, RAM word width.
- RD_LAT, 1, RAM read latency in cycles (>=1); data valid RD_LAT cycles after the address is presented.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- m0_cmd  input  2  port-0 command: 00 none, 01 read, 10 write, 11 illegal (treated as none).
- m0_addr  input  ADDR_W  port-0 word address.
- m0_wdata  input  DATA_W  port-0 write data.
- m0_rdata  output  DATA_W  port-0 read data.
- m0_ready  output  1  port-0 transaction complete (1-cycle pulse).
- m1_cmd  input  2  port-1 command; same encoding as m0_cmd.
- m1_addr  input  ADDR_W  port-1 word address.
- m1_wdata  input  DATA_W  port-1 write data.
- m1_rdata  output  DATA_W  port-1 read data.
- m1_ready  output  1  port-1 transaction complete (1-cycle pulse).
- ram_addr  output  ADDR_W  registered RAM address.
- ram_wdata  output  DATA_W  registered RAM write data.
- ram_write  output  1  RAM write enable.
- ram_rdata  input  DATA_W  RAM read data.
- grant  output  1  index of the port currently being served (valid outside IDLE).
- illegal_cmd  output  1  sticky: a port presented cmd 11.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; ram_write=0; ram_addr=0; ram_wdata=0.
  - m0_ready=m1_ready=0; m0_rdata=m1_rdata=0.
  - grant=0; last_grant=1, so port 0 wins the first tie.
  - illegal_cmd=0.
  - Reset mid-transaction aborts it: no ready pulse; any pending write is dropped if reset is sampled in the ACC cycle.
- Requester rules:
  - Holds cmd/addr/wdata stable from assertion until it samples its ready=1 at a posedge.
  - May present a new cmd in the following cycle.
- States:
  - IDLE: no RAM drive (ram_write=0).
    - If any valid cmd (01/10) is present, pick a winner and latch its cmd, addr and wdata into ram_addr/ram_wdata/op.
    - Set grant=winner; go to ACC.
  - ACC (1 cycle): ram_addr driven.
    - Write: ram_write=1 and winner's ready=1 this cycle; the RAM commits at the closing edge; next state IDLE.
    - Read: ram_write=0; load wait counter=RD_LAT; go to RDW.
  - RDW: decrement the counter each cycle.
    - In the cycle where the counter reaches 1, winner's ready=1 and winner's rdata follows ram_rdata combinationally.
    - ram_rdata is also captured into the winner's rdata register, which holds until that port's next read completes.
    - Next state IDLE.
- Latency from a cmd sampled in IDLE:
  - Write completes 1 cycle later.
  - Read completes 1+RD_LAT cycles later.
  - The next arbitration happens in the IDLE cycle after completion, so back-to-back throughput is one transaction per 2 (write) or 2+RD_LAT (read) cycles.
- Arbitration (round-robin):
  - Single requester wins.
  - Both requesting: the port != last_grant wins; last_grant is updated on entry to ACC.
- Command and output rules:
  - cmd 11 in IDLE sets illegal_cmd, which clears only on reset; it is never granted.
  - Changes to a non-granted port's inputs during a transaction have no effect.
  - The non-granted port's ready is always 0.
  - ready is never asserted for both ports in the same cycle.
  - ram_write is asserted only in ACC for write ops.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: strict priority; port 0 (CPU) always wins when both request, and last_grant is ignored.
- Undefined: round-robin as above.
- Neither mode changes state or latency.

Test Plan:
- Reset, then port 0 writes 16'hFFE9 to addr 25 -> m0_ready=1 exactly 1 cycle after the request is sampled, ram_write=1 in that same cycle; a later port-1 read of addr 25 returns 16'hFFE9 on m1_rdata with m1_ready at cycle 1+RD_LAT.
- Both ports request every cycle (p0 read addr 0, p1 write addr 1) -> grants alternate 0,1,0,1; no ready overlap; each port completes every second transaction. With MEM_ARB_FIXED_PRIO_EN, only port 0 is served while it keeps requesting.
- RD_LAT=3, port-1 read of a preloaded addr 7=16'h1234 -> m1_ready 4 cycles after sampling; m1_rdata=16'h1234, held after ready drops.
- Assert reset in the ACC cycle of a port-0 write to addr 5 (old value 16'h0000) -> no m0_ready, addr 5 stays 16'h0000, state IDLE, grant=0.
- Port 0 presents cmd 11 -> illegal_cmd=1 and stays 1, no RAM access, no ready; a subsequent valid port-1 read proceeds normally.
- A port-1 write of 16'hAAAA to addr 2 is in RDW/ACC while port 0 changes its addr every cycle -> ram_addr stays 2 throughout; port 0 is served next with its address as sampled in the following IDLE cycle.
